// File: rtl/interp_buf_pkg.sv
// Shared types and helpers for the interpolation column buffer.
// Block geometry, counter width, FSM states and the column transpose.
package interp_buf_pkg;

  localparam int SAMPLE_W  = 9;
  localparam int N_SAMPLES = 11;
  localparam int LINE_W    = SAMPLE_W * N_SAMPLES;
  localparam int CNT_W     = $clog2(N_SAMPLES);

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef line_t [N_SAMPLES-1:0] block_t;

  localparam cnt_t LAST = cnt_t'(N_SAMPLES - 1);

  typedef enum logic {
    FILL,
    DRAIN
  } state_t;

  function automatic line_t transpose_col(
    input block_t s,
    input cnt_t   c
  );
    line_t r;
    r = '0;
    for (int i = 0; i < N_SAMPLES; i++)
      r[i*SAMPLE_W +: SAMPLE_W] =
        s[i][int'(c)*SAMPLE_W +: SAMPLE_W];
    return r;
  endfunction

endpackage

// File: rtl/interp_col_bank.sv
// Row storage for one block with a transposing column read port.
// The read sees a same-cycle write so the last row is visible at once.
module interp_col_bank
  import interp_buf_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  cnt_t  waddr,
  input  line_t wdata,
  input  cnt_t  rcol,
  output line_t col
);

  block_t mem;
  block_t view;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    view = mem;
    if (we) view[waddr] = wdata;
  end

  assign col = transpose_col(view, rcol);

endmodule

// File: rtl/interp_col_buffer.sv
// Transposing line-to-column block buffer feeding the interp input mux.
// Define INTERP_BUF_PINGPONG_EN for two banks (fill overlaps drain).
module interp_col_buffer
  import interp_buf_pkg::*;
(
  input  logic  CLK,
  input  logic  RST_N,
  input  logic  FLUSH,
  input  line_t LINE_IN,
  input  logic  LINE_VALID,
  output logic  LINE_READY,
  output line_t COL_OUT,
  output logic  COL_VALID,
  input  logic  COL_READY,
  output logic  SEL_LINE_IN,
  output logic  BLOCK_DONE
);

`ifdef INTERP_BUF_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  state_t     state, state_n;
  cnt_t       row_cnt, row_n;
  cnt_t       col_cnt, col_n;
  logic [1:0] full, full_n;
  logic       wp, wp_n;
  logic       rp, rp_n;
  cnt_t       rd_col;
  line_t      col_rd;
  logic       load, done_n;
  logic       accept, fill_last;
  logic       take, drain_last;

  // A bank is full from its last line until its last column leaves
  assign LINE_READY  = ~full[wp];
  assign COL_VALID   = (state == DRAIN);
  assign SEL_LINE_IN = ~COL_VALID;

  always_comb begin
    accept     = LINE_VALID & LINE_READY & ~FLUSH;
    fill_last  = accept & (row_cnt == LAST);
    take       = COL_VALID & COL_READY & ~FLUSH;
    drain_last = take & (col_cnt == LAST);
    state_n = state;
    row_n   = row_cnt;
    col_n   = col_cnt;
    full_n  = full;
    wp_n    = wp;
    rp_n    = rp;
    rd_col  = '0;
    load    = 1'b0;
    done_n  = 1'b0;
    if (accept) row_n = fill_last ? '0 : row_cnt + 1'b1;
    if (fill_last) begin
      full_n[wp] = 1'b1;
      wp_n       = wp ^ PP;
    end
    if (drain_last) begin
      full_n[rp] = 1'b0;
      rp_n       = rp ^ PP;
    end
    unique case (state)
      FILL: begin
        if (fill_last) begin
          state_n = DRAIN;
          load    = 1'b1;
        end
      end
      DRAIN: begin
        done_n = drain_last;
        if (drain_last) begin
          col_n = '0;
          if (full_n[rp_n]) load = 1'b1;
          else state_n = FILL;
        end else if (take) begin
          col_n  = col_cnt + 1'b1;
          rd_col = col_n;
          load   = 1'b1;
        end
      end
      default: ;
    endcase
    if (FLUSH) begin
      state_n = FILL;
      row_n   = '0;
      col_n   = '0;
      full_n  = '0;
      wp_n    = 1'b0;
      rp_n    = 1'b0;
      load    = 1'b0;
      done_n  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= FILL;
      row_cnt    <= '0;
      col_cnt    <= '0;
      full       <= '0;
      wp         <= 1'b0;
      rp         <= 1'b0;
      COL_OUT    <= '0;
      BLOCK_DONE <= 1'b0;
    end else begin
      state      <= state_n;
      row_cnt    <= row_n;
      col_cnt    <= col_n;
      full       <= full_n;
      wp         <= wp_n;
      rp         <= rp_n;
      BLOCK_DONE <= done_n;
      if (load) COL_OUT <= col_rd;
    end
  end

`ifdef INTERP_BUF_PINGPONG_EN
  line_t col0, col1;
  logic  rd_bank;

  // Idle FILL starts draining the bank it just filled
  assign rd_bank = (state == DRAIN) ? rp_n : wp;
  assign col_rd  = rd_bank ? col1 : col0;

  interp_col_bank u_bank0 (
    .clk   (CLK),
    .we    (accept & ~wp),
    .waddr (row_cnt),
    .wdata (LINE_IN),
    .rcol  (rd_col),
    .col   (col0)
  );

  interp_col_bank u_bank1 (
    .clk   (CLK),
    .we    (accept & wp),
    .waddr (row_cnt),
    .wdata (LINE_IN),
    .rcol  (rd_col),
    .col   (col1)
  );
`else
  interp_col_bank u_bank0 (
    .clk   (CLK),
    .we    (accept),
    .waddr (row_cnt),
    .wdata (LINE_IN),
    .rcol  (rd_col),
    .col   (col_rd)
  );
`endif

endmodule

// File: tb/tb_interp_col_buffer.sv
// Scoreboard bench for interp_col_buffer.
// Columns are predicted when a block's last line is accepted.
module tb_interp_col_buffer;
  import interp_buf_pkg::*;

  logic  CLK = 1'b0;
  logic  RST_N = 1'b1;
  logic  FLUSH = 1'b0;
  line_t LINE_IN = '0;
  logic  LINE_VALID = 1'b0;
  logic  LINE_READY;
  line_t COL_OUT;
  logic  COL_VALID;
  logic  COL_READY = 1'b0;
  logic  SEL_LINE_IN;
  logic  BLOCK_DONE;

  always #5 CLK = ~CLK;

  interp_col_buffer dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .FLUSH       (FLUSH),
    .LINE_IN     (LINE_IN),
    .LINE_VALID  (LINE_VALID),
    .LINE_READY  (LINE_READY),
    .COL_OUT     (COL_OUT),
    .COL_VALID   (COL_VALID),
    .COL_READY   (COL_READY),
    .SEL_LINE_IN (SEL_LINE_IN),
    .BLOCK_DONE  (BLOCK_DONE)
  );

  int    n_cmp = 0;
  int    n_err = 0;
  line_t exp_q[$];
  line_t rows[N_SAMPLES];
  int    mrow = 0;
  int    sel_low = 0;
  int    done_cnt = 0;
  int    pops = 0;
  int    cyc = 0;
  int    last_pop = 0;
  logic  hold_v = 1'b0;
  line_t held = '0;

  task automatic check(input string tag, input line_t got,
                       input line_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic line_t mk(input int seed, input int r);
    line_t l;
    l = '0;
    for (int k = 0; k < N_SAMPLES; k++)
      l[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(seed + 16*r + k);
    return l;
  endfunction

  task automatic push_block();
    line_t c;
    for (int ci = 0; ci < N_SAMPLES; ci++) begin
      c = '0;
      for (int r = 0; r < N_SAMPLES; r++)
        c[r*SAMPLE_W +: SAMPLE_W] = rows[r][ci*SAMPLE_W +: SAMPLE_W];
      exp_q.push_back(c);
    end
  endtask

  always @(negedge CLK) begin
    cyc++;
    if (!RST_N) begin
      hold_v = 1'b0;
    end else begin
      if (!SEL_LINE_IN) sel_low++;
      if (BLOCK_DONE) done_cnt++;
`ifndef INTERP_BUF_PINGPONG_EN
      if (COL_VALID) check("ready_in_drain", line_t'(LINE_READY), '0);
`endif
      if (hold_v && COL_VALID) check("stall_hold", COL_OUT, held);
      hold_v = COL_VALID && !COL_READY;
      held   = COL_OUT;
      if (COL_VALID && COL_READY) begin
        if (exp_q.size() == 0)
          check("unexpected_col", line_t'(COL_VALID), '0);
        else
          check("col", COL_OUT, exp_q.pop_front());
        pops++;
        last_pop = cyc;
      end
    end
  end

  task automatic put_line(input line_t l);
    int n;
    n = 0;
    LINE_IN = l;
    LINE_VALID = 1'b1;
    @(negedge CLK);
    while (!LINE_READY && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (!LINE_READY) begin
      check("line_accept_timeout", line_t'(LINE_READY), line_t'(1));
      LINE_VALID = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
    LINE_VALID = 1'b0;
    rows[mrow] = l;
    mrow++;
    if (mrow == N_SAMPLES) begin
      mrow = 0;
      push_block();
      check("first_col_latency", line_t'(COL_VALID), line_t'(1));
    end
  endtask

  task automatic send_block(input int seed);
    for (int r = 0; r < N_SAMPLES; r++) put_line(mk(seed, r));
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge CLK);
      n++;
    end
    check("drain_timeout", line_t'(exp_q.size()), '0);
  endtask

  task automatic wait_pops(input int target);
    int n;
    n = 0;
    while (pops < target && n < 200) begin
      @(posedge CLK);
      n++;
    end
    check("pop_timeout", line_t'(pops >= target), line_t'(1));
  endtask

  initial begin
    int s0, d0, p0, t0, t1, c0, n;

    #2 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_line_ready", line_t'(LINE_READY), line_t'(1));
    check("rst_col_valid", line_t'(COL_VALID), '0);
    check("rst_sel", line_t'(SEL_LINE_IN), line_t'(1));
    check("rst_done", line_t'(BLOCK_DONE), '0);
    check("rst_col_out", COL_OUT, '0);
    RST_N = 1'b1;

    // basic block, full-rate drain
    COL_READY = 1'b1;
    s0 = sel_low;
    d0 = done_cnt;
    p0 = pops;
    send_block(0);
    wait_pops(p0 + 1);
    t0 = last_pop;
    wait_drain(100);
    t1 = last_pop;
    check("throughput", line_t'(t1 - t0), line_t'(N_SAMPLES - 1));
    repeat (3) @(negedge CLK);
    check("sel_low_cycles", line_t'(sel_low - s0), line_t'(N_SAMPLES));
    check("block_done_pulses", line_t'(done_cnt - d0), line_t'(1));

    // backpressure with toggling ready
    @(posedge CLK);
    #1;
    COL_READY = 1'b0;
    p0 = pops;
    send_block(100);
    repeat (3) @(posedge CLK);
    #1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge CLK);
      #1;
      COL_READY = ~COL_READY;
      n++;
    end
    check("stall_drain", line_t'(exp_q.size()), '0);
    check("stall_col_count", line_t'(pops - p0), line_t'(N_SAMPLES));
    COL_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;

`ifndef INTERP_BUF_PINGPONG_EN
    // lines offered during drain must be ignored
    send_block(200);
    LINE_IN = mk(999, 0);
    LINE_VALID = 1'b1;
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (COL_VALID && n < 50);
    check("junk_window_end", line_t'(COL_VALID), '0);
    LINE_VALID = 1'b0;
    send_block(300);
    wait_drain(100);
    repeat (2) @(posedge CLK);
    #1;
`endif

    // flush after a partial block
    for (int r = 0; r < 5; r++) put_line(mk(400, r));
    FLUSH = 1'b1;
    LINE_IN = mk(500, 0);
    LINE_VALID = 1'b1;
    @(posedge CLK);
    #1;
    FLUSH = 1'b0;
    LINE_VALID = 1'b0;
    mrow = 0;
    check("flush_line_ready", line_t'(LINE_READY), line_t'(1));
    check("flush_col_valid", line_t'(COL_VALID), '0);
    send_block(600);
    wait_drain(100);
    repeat (2) @(posedge CLK);
    #1;

    // async reset while column 4 is presented
    p0 = pops;
    send_block(700);
    wait_pops(p0 + 4);
    #2;
    RST_N = 1'b0;
    exp_q.delete();
    #1;
    check("arst_col_valid", line_t'(COL_VALID), '0);
    check("arst_sel", line_t'(SEL_LINE_IN), line_t'(1));
    check("arst_line_ready", line_t'(LINE_READY), line_t'(1));
    check("arst_col_out", COL_OUT, '0);
    check("arst_done", line_t'(BLOCK_DONE), '0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    mrow = 0;
    check("post_rst_line_ready", line_t'(LINE_READY), line_t'(1));
    check("post_rst_col_valid", line_t'(COL_VALID), '0);
    send_block(800);
    wait_drain(100);
    repeat (2) @(posedge CLK);
    #1;

`ifdef INTERP_BUF_PINGPONG_EN
    // three blocks back to back, fill overlapping drain
    c0 = cyc;
    for (int b = 0; b < 3; b++) send_block(900 + 37*b);
    check("pp_line_rate", line_t'(cyc - c0), line_t'(3*N_SAMPLES));
    wait_drain(100);
    check("pp_stream", line_t'(last_pop - c0), line_t'(4*N_SAMPLES));
    repeat (2) @(posedge CLK);
    #1;
`else
    c0 = 0;
`endif

    check("queue_empty", line_t'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
